// File: rtl/complex_upconverter.sv
// complex_upconverter
// Transmit-side complex upconverter. Baseband I/Q samples are rotated up to RF
// by an internal NCO: a phase accumulator whose MSBs address a full-cycle sine
// table. The datapath is a 4-stage pipeline with an input handshake, round-half-up
// scaling and saturation to the DAC width.
//
// Ports
//   clock        single clock, rising edge
//   reset_n      asynchronous, active-low reset
//   clk_en       sample-rate enable; every piece of state freezes while low
//   freq_word    phase increment per accepted sample (unsigned)
//   freq_load    latch freq_word into the frequency register (qualified by clk_en)
//   phase_clear  zero the phase accumulator (qualified by clk_en)
//   bb_i, bb_q   baseband input sample, signed
//   in_valid     bb_i/bb_q valid
//   in_ready     block accepts a sample this cycle
//   rf_i, rf_q   upconverted output sample, signed
//   out_valid    rf_i/rf_q valid
//   sat_flag     current output sample was clipped on either rail
module complex_upconverter #(
  parameter int IWIDTH   = 16,
  parameter int OWIDTH   = 8,
  parameter int PHASE_W  = 24,
  parameter int LUT_ADDR = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clk_en,
  input  logic [PHASE_W-1:0]       freq_word,
  input  logic                     freq_load,
  input  logic                     phase_clear,
  input  logic signed [IWIDTH-1:0] bb_i,
  input  logic signed [IWIDTH-1:0] bb_q,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [OWIDTH-1:0] rf_i,
  output logic signed [OWIDTH-1:0] rf_q,
  output logic                     out_valid,
  output logic                     sat_flag
);

  localparam int LUT_SIZE = 2 ** LUT_ADDR;
  localparam int PW       = IWIDTH + 8;
  localparam int YW       = IWIDTH + 9;
  localparam int SHIFT    = IWIDTH + 7 - OWIDTH;
  localparam real PI      = 3.14159265358979323846;

  localparam logic [LUT_ADDR-1:0]   QUARTER = LUT_ADDR'(LUT_SIZE / 4);
  localparam logic signed [YW-1:0]  RND     = YW'(2 ** (SHIFT - 1));
  localparam logic signed [YW-1:0]  SAT_MAX = YW'(2 ** (OWIDTH - 1) - 1);
  localparam logic signed [YW-1:0]  SAT_MIN = YW'(-(2 ** (OWIDTH - 1)));

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, next_state;

  logic [PHASE_W-1:0]  phase, freq_reg;
  logic [LUT_ADDR-1:0] idx_q, idx_i;
  logic                accept;

  logic signed [7:0] sin_lut [LUT_SIZE];

  logic                     s1_valid, s2_valid, s3_valid;
  logic signed [IWIDTH-1:0] s1_bi, s1_bq;
  logic signed [7:0]        s1_li, s1_lq;
  logic signed [PW-1:0]     s2_ii, s2_qq, s2_iq, s2_qi;
  logic signed [YW-1:0]     s3_yi, s3_yq;
  logic [OWIDTH:0]          sat_i, sat_q;

  // Rounded (half away from zero) 127*sin entry, evaluated at elaboration.
  function automatic logic signed [7:0] sin_entry(input int k);
    real v;
    v = 127.0 * $sin(2.0 * PI * real'(k) / real'(LUT_SIZE));
    return 8'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  // Scales y down to OWIDTH with round-half-up; returns {clipped, value}.
  function automatic logic [OWIDTH:0] saturate(input logic signed [YW-1:0] y);
    logic signed [YW-1:0] r;
    r = (y + RND) >>> SHIFT;
    if (r > SAT_MAX)      return {1'b1, SAT_MAX[OWIDTH-1:0]};
    else if (r < SAT_MIN) return {1'b1, SAT_MIN[OWIDTH-1:0]};
    else                  return {1'b0, r[OWIDTH-1:0]};
  endfunction

  for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
    assign sin_lut[k] = sin_entry(k);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    state <= IDLE;
    else if (clk_en) state <= next_state;
  end

  // The block stays idle until it has been given a frequency, then runs forever.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: if (clk_en && freq_load) next_state = RUN;
      RUN:  in_ready = clk_en;
      default: next_state = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // A clear coinciding with an accept makes that sample see phase 0.
  assign idx_q = phase_clear ? '0 : phase[PHASE_W-1 -: LUT_ADDR];
  assign idx_i = idx_q + QUARTER;

  // The accumulator steps by the frequency held at the start of the cycle, so a
  // same-cycle load only affects the following accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= '0;
      freq_reg <= '0;
    end else if (clk_en) begin
      if (phase_clear)  phase <= accept ? freq_reg : '0;
      else if (accept)  phase <= phase + freq_reg;
      if (freq_load)    freq_reg <= freq_word;
    end
  end

  assign sat_i = saturate(s3_yi);
  assign sat_q = saturate(s3_yq);

  // Four-stage datapath: capture, multiply, combine, round/saturate. Valid tags
  // travel with the data; bubbles drive the DAC to mid-scale.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s1_bi     <= '0;
      s1_bq     <= '0;
      s1_li     <= '0;
      s1_lq     <= '0;
      s2_ii     <= '0;
      s2_qq     <= '0;
      s2_iq     <= '0;
      s2_qi     <= '0;
      s3_yi     <= '0;
      s3_yq     <= '0;
      rf_i      <= '0;
      rf_q      <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (clk_en) begin
      s1_valid <= accept;
      s1_bi    <= bb_i;
      s1_bq    <= bb_q;
      s1_li    <= sin_lut[idx_i];
      s1_lq    <= sin_lut[idx_q];

      s2_valid <= s1_valid;
      s2_ii    <= PW'(s1_bi) * PW'(s1_li);
      s2_qq    <= PW'(s1_bq) * PW'(s1_lq);
      s2_iq    <= PW'(s1_bi) * PW'(s1_lq);
      s2_qi    <= PW'(s1_bq) * PW'(s1_li);

      s3_valid <= s2_valid;
      s3_yi    <= YW'(s2_ii) - YW'(s2_qq);
      s3_yq    <= YW'(s2_iq) + YW'(s2_qi);

      out_valid <= s3_valid;
      if (s3_valid) begin
        rf_i     <= sat_i[OWIDTH-1:0];
        rf_q     <= sat_q[OWIDTH-1:0];
        sat_flag <= sat_i[OWIDTH] | sat_q[OWIDTH];
      end else begin
        rf_i     <= '0;
        rf_q     <= '0;
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_complex_upconverter.sv
// tb_complex_upconverter
// Directed bench for complex_upconverter. A behavioural NCO/mixer model pushes the
// expected RF sample onto a scoreboard queue, tagged with the enabled cycle on
// which it must appear; outputs are compared one time unit after each clock edge.
module tb_complex_upconverter;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               clk_en;
  logic [23:0]        freq_word;
  logic               freq_load;
  logic               phase_clear;
  logic signed [15:0] bb_i, bb_q;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  rf_i, rf_q;
  logic               out_valid;
  logic               sat_flag;

  typedef struct {
    int due;
    int ri;
    int rq;
    int sat;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          en_cnt     = 0;
  logic [23:0] m_phase, m_freq;
  bit          m_run;
  bit          last_accept;
  int          exp_valid, exp_i, exp_q, exp_sat;
  int          accepted_n;

  complex_upconverter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clk_en      (clk_en),
    .freq_word   (freq_word),
    .freq_load   (freq_load),
    .phase_clear (phase_clear),
    .bb_i        (bb_i),
    .bb_q        (bb_q),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rf_i        (rf_i),
    .rf_q        (rf_q),
    .out_valid   (out_valid),
    .sat_flag    (sat_flag)
  );

  always #5 clock = ~clock;

  function automatic int lutModel(input int k);
    real v;
    v = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 256.0);
    return $rtoi($floor(v + 0.5));
  endfunction

  task automatic checkValue(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected mixer output for one accepted sample at LUT index idx.
  task automatic pushExpected(input int bi, input int bq, input int idx);
    exp_t e;
    int li, lq, yi, yq, ri, rq;
    li = lutModel((idx + 64) % 256);
    lq = lutModel(idx);
    yi = bi * li - bq * lq;
    yq = bi * lq + bq * li;
    ri = (yi + 16384) >>> 15;
    rq = (yq + 16384) >>> 15;
    e.sat = 0;
    if (ri > 127)  begin ri = 127;  e.sat = 1; end
    if (ri < -128) begin ri = -128; e.sat = 1; end
    if (rq > 127)  begin rq = 127;  e.sat = 1; end
    if (rq < -128) begin rq = -128; e.sat = 1; end
    e.ri  = ri;
    e.rq  = rq;
    e.due = en_cnt + 4;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input bit en);
    exp_t e;
    if (en) begin
      if (sb.size() > 0 && sb[0].due == en_cnt) begin
        e = sb.pop_front();
        exp_valid = 1; exp_i = e.ri; exp_q = e.rq; exp_sat = e.sat;
      end else begin
        exp_valid = 0; exp_i = 0; exp_q = 0; exp_sat = 0;
      end
    end
    checkValue("out_valid", out_valid, exp_valid);
    checkValue("rf_i", rf_i, exp_i);
    checkValue("rf_q", rf_q, exp_q);
    checkValue("sat_flag", sat_flag, exp_sat);
  endtask

  // Drives one cycle of inputs, updates the model, then checks the outputs.
  task automatic applyStimulus(input bit en, input bit valid, input int bi, input int bq,
                               input bit load, input logic [23:0] fw, input bit clr);
    clk_en      = en;
    in_valid    = valid;
    bb_i        = 16'(bi);
    bb_q        = 16'(bq);
    freq_load   = load;
    freq_word   = fw;
    phase_clear = clr;
    #1;
    checkValue("in_ready", in_ready, m_run && en);
    last_accept = valid && m_run && en;
    if (last_accept) pushExpected(bi, bq, clr ? 0 : int'(m_phase[23:16]));
    if (en) begin
      if (clr)              m_phase = last_accept ? m_freq : 24'd0;
      else if (last_accept) m_phase = m_phase + m_freq;
      if (load) begin
        m_freq = fw;
        m_run  = 1'b1;
      end
    end
    @(posedge clock);
    if (en) en_cnt++;
    #1;
    checkOutput(en);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 24'd0, 0);
  endtask

  // Asynchronous reset asserted between edges while samples are in flight.
  task automatic doReset();
    #2 reset_n = 1'b0;
    #1;
    sb.delete();
    m_phase = '0; m_freq = '0; m_run = 1'b0;
    exp_valid = 0; exp_i = 0; exp_q = 0; exp_sat = 0;
    checkValue("reset_out_valid", out_valid, 0);
    checkValue("reset_rf_i", rf_i, 0);
    checkValue("reset_rf_q", rf_q, 0);
    checkValue("reset_sat_flag", sat_flag, 0);
    checkValue("reset_in_ready", in_ready, 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; clk_en = 1'b1; freq_word = '0; freq_load = 1'b0;
    phase_clear = 1'b0; bb_i = '0; bb_q = '0; in_valid = 1'b0;
    m_phase = '0; m_freq = '0; m_run = 1'b0;
    exp_valid = 0; exp_i = 0; exp_q = 0; exp_sat = 0;
    repeat (2) @(posedge clock);
    #1;
    checkValue("por_out_valid", out_valid, 0);
    checkValue("por_rf_i", rf_i, 0);
    checkValue("por_rf_q", rf_q, 0);
    checkValue("por_sat_flag", sat_flag, 0);
    checkValue("por_in_ready", in_ready, 0);
    #1 reset_n = 1'b1;

    // Not ready until a frequency has been loaded, even with in_valid high.
    $display("[TB] idle before freq_load");
    applyStimulus(1, 1, 1000, 1000, 0, 24'd0, 0);
    applyStimulus(1, 1, 1000, 1000, 0, 24'd0, 0);
    // A load while disabled is ignored.
    applyStimulus(0, 1, 1000, 1000, 1, 24'h400000, 0);

    $display("[TB] DC single sample");
    applyStimulus(1, 0, 0, 0, 1, 24'd0, 0);
    applyStimulus(1, 1, 16384, 0, 0, 24'd0, 0);
    idle(6);

    $display("[TB] quarter-rate stream");
    applyStimulus(1, 0, 0, 0, 1, 24'h400000, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 16384, 0, 0, 24'd0, 0);
    idle(5);

    $display("[TB] quarter-rate with clk_en gaps");
    applyStimulus(1, 0, 0, 0, 0, 24'd0, 1);
    accepted_n = 0;
    for (int n = 0; n < 200 && accepted_n < 8; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1, 16384, 0, 0, 24'd0, 0);
      if (last_accept) accepted_n++;
    end
    checkValue("gap_accepts", accepted_n, 8);
    for (int n = 0; n < 30; n++) applyStimulus(1'($urandom_range(0, 1)), 0, 0, 0, 0, 24'd0, 0);
    idle(5);

    $display("[TB] saturation at eighth-rate");
    applyStimulus(1, 0, 0, 0, 1, 24'h200000, 1);
    applyStimulus(1, 1, 0, 0, 0, 24'd0, 0);
    applyStimulus(1, 1, 32767, -32767, 0, 24'd0, 0);
    applyStimulus(1, 1, -32768, 32767, 0, 24'd0, 0);
    applyStimulus(1, 1, -32768, -32767, 0, 24'd0, 0);
    applyStimulus(1, 1, 32767, 32767, 0, 24'd0, 0);
    applyStimulus(1, 0, 0, 0, 0, 24'd0, 1);
    applyStimulus(1, 1, 0, 0, 0, 24'd0, 0);
    applyStimulus(1, 1, -32768, -32768, 0, 24'd0, 0);
    idle(6);

    $display("[TB] retune on an accept");
    applyStimulus(1, 0, 0, 0, 1, 24'h123456, 1);
    applyStimulus(1, 1, 12000, -5000, 0, 24'd0, 0);
    applyStimulus(1, 1, -7000, 9000, 1, 24'h0ABCDE, 0);
    applyStimulus(1, 1, 20000, 3000, 0, 24'd0, 0);
    applyStimulus(1, 1, -15000, -22000, 0, 24'd0, 0);
    applyStimulus(1, 1, 8191, 30000, 0, 24'd0, 0);
    idle(5);

    $display("[TB] phase wrap with random samples");
    applyStimulus(1, 0, 0, 0, 1, 24'hF00000, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 1, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768, 0, 24'd0, 0);
    idle(5);

    $display("[TB] reset mid-stream");
    applyStimulus(1, 0, 0, 0, 1, 24'h300000, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 10000 - 3000 * i, 2000 * i, 0, 24'd0, 0);
    doReset();
    applyStimulus(1, 1, 5000, 5000, 0, 24'd0, 0);
    applyStimulus(1, 1, 5000, 5000, 0, 24'd0, 0);
    idle(4);
    applyStimulus(1, 0, 0, 0, 1, 24'h555555, 0);
    applyStimulus(1, 1, 16384, -16384, 0, 24'd0, 0);
    applyStimulus(1, 1, -16384, 16384, 0, 24'd0, 0);
    idle(6);

    checkValue("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
